// File: rtl/ex_pkg.sv
// ex_pkg: opcode/funct encodings, mul/div FSM states and decode helper for the EX stage
package ex_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL    = 6'h00;
  localparam logic [5:0] F_SRL    = 6'h02;
  localparam logic [5:0] F_MULT   = 6'h18;
  localparam logic [5:0] F_DIVU   = 6'h1B;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUBU   = 6'h23;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_XOR    = 6'h26;
  localparam logic [5:0] F_SLT    = 6'h2A;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
  function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] funct);
    return op == OP_RTYPE && (funct == F_MULT || funct == F_DIVU);
  endfunction
endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative shift-add multiplier / restoring divider, one step per cycle
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int W = 32,
  parameter int MD_CYCLES = W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sel,
  input  logic         mem_stall_c,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output md_state_t    md_state,
  output logic         done,
  output logic [W-1:0] result
);
  localparam int CW = $clog2(MD_CYCLES + 1);
  md_state_t state_q, state_d;
  logic op_q, op_d;
  logic [W-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0] rem_sh;
  logic fits;
  // op_q=1 is DIVU: acc holds the partial remainder, x shifts dividend out and quotient in
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    acc_d = acc_q;
    x_d = x_q;
    y_d = y_q;
    cnt_d = cnt_q;
    rem_sh = {acc_q, x_q[W-1]};
    fits = rem_sh >= {1'b0, y_q};
    case (state_q)
      MD_IDLE: if (start) begin
        state_d = MD_BUSY;
        op_d = op_sel;
        acc_d = '0;
        x_d = a;
        y_d = b;
        cnt_d = CW'(MD_CYCLES - 1);
      end
      MD_BUSY: begin
        if (op_q) begin
          x_d = {x_q[W-2:0], fits};
          acc_d = fits ? W'(rem_sh - {1'b0, y_q}) : rem_sh[W-1:0];
        end else begin
          acc_d = x_q[0] ? acc_q + y_q : acc_q;
          x_d = x_q >> 1;
          y_d = y_q << 1;
        end
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? MD_DONE : MD_BUSY;
      end
      MD_DONE: state_d = mem_stall_c ? MD_DONE : MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    state_q <= reset ? MD_IDLE : state_d;
    op_q <= op_d;
    acc_q <= acc_d;
    x_q <= x_d;
    y_q <= y_d;
    cnt_q <= cnt_d;
  end
  assign md_state = state_q;
  assign done = state_q == MD_DONE;
  assign result = op_q ? x_q : acc_q;
endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage - ALU/branch decode, EX_MEM register bank and stall generation
module execute_stage
  import ex_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int MD_CYCLES = DATA_SIZE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ID_EX_valid,
  input  logic [5:0]              ID_EX_op,
  input  logic [5:0]              ID_EX_funct,
  input  logic [4:0]              ID_EX_shamt,
  input  logic [DATA_SIZE-1:0]    ID_EX_A,
  input  logic [DATA_SIZE-1:0]    ID_EX_B,
  input  logic [15:0]             ID_EX_imm,
  input  logic [4:0]              ID_EX_dest,
  input  logic [ADDRESS_SIZE-1:0] ID_EX_PC,
  input  logic                    mem_stall_c,
  output logic [ADDRESS_SIZE-1:0] EX_MEM_targetPC,
  output logic [DATA_SIZE-1:0]    EX_MEM_result,
  output logic [DATA_SIZE-1:0]    EX_MEM_B,
  output logic [4:0]              EX_MEM_dest,
  output logic [5:0]              EX_MEM_op,
  output logic                    EX_MEM_taken,
  output logic                    EX_MEM_valid,
  output logic                    ex_stall_c
);
  localparam int EW = 1 + ADDRESS_SIZE + 2 * DATA_SIZE + 5 + 6 + 1;
  logic [EW-1:0] exm_q, exm_d;
  logic [4:0] md_dest_q, md_dest_d;
  logic ok, tkn, md, md_done;
  logic [DATA_SIZE-1:0] res, simm, zimm, md_result;
  logic [4:0] dst;
  logic [ADDRESS_SIZE-1:0] pc4, target;
  md_state_t md_state;
  assign simm = {{(DATA_SIZE-16){ID_EX_imm[15]}}, ID_EX_imm};
  assign zimm = {{(DATA_SIZE-16){1'b0}}, ID_EX_imm};
  assign md = is_muldiv(ID_EX_op, ID_EX_funct);
  always_comb begin
    ok = 1'b1;
    res = '0;
    dst = ID_EX_dest;
    tkn = 1'b0;
    case (ID_EX_op)
      OP_RTYPE: case (ID_EX_funct)
        F_ADDU: res = ID_EX_A + ID_EX_B;
        F_SUBU: res = ID_EX_A - ID_EX_B;
        F_AND:  res = ID_EX_A & ID_EX_B;
        F_OR:   res = ID_EX_A | ID_EX_B;
        F_XOR:  res = ID_EX_A ^ ID_EX_B;
        F_SLT:  res = DATA_SIZE'($signed(ID_EX_A) < $signed(ID_EX_B));
        F_SLL:  res = ID_EX_B << ID_EX_shamt;
        F_SRL:  res = ID_EX_B >> ID_EX_shamt;
        F_MULT, F_DIVU: res = '0;
        default: ok = 1'b0;
      endcase
      OP_ADDIU, OP_LW: res = ID_EX_A + simm;
      OP_ANDI: res = ID_EX_A & zimm;
      OP_ORI:  res = ID_EX_A | zimm;
      OP_LUI:  res = {ID_EX_imm, {(DATA_SIZE-16){1'b0}}};
      OP_SW: begin
        res = ID_EX_A + simm;
        dst = '0;
      end
      OP_BEQ, OP_BNE: begin
        dst = '0;
        tkn = (ID_EX_A == ID_EX_B) ^ (ID_EX_op == OP_BNE);
      end
      default: ok = 1'b0;
    endcase
  end
  assign pc4 = ID_EX_PC + ADDRESS_SIZE'(4);
  assign target = tkn ? pc4 + {{(ADDRESS_SIZE-18){ID_EX_imm[15]}}, ID_EX_imm, 2'b00} : pc4;
  ex_muldiv_unit #(.W(DATA_SIZE), .MD_CYCLES(MD_CYCLES)) u_md (
    .clock(clock), .reset(reset), .start(ID_EX_valid && md), .op_sel(ID_EX_funct == F_DIVU),
    .mem_stall_c(mem_stall_c), .a(ID_EX_A), .b(ID_EX_B),
    .md_state(md_state), .done(md_done), .result(md_result)
  );
  assign ex_stall_c = mem_stall_c || (md_state == MD_IDLE && ID_EX_valid && md) || md_state == MD_BUSY;
  assign md_dest_d = (md_state == MD_IDLE && ID_EX_valid && md) ? ID_EX_dest : md_dest_q;
  // a mul/div commit takes priority; everything else not a live single-cycle op becomes an all-zero bubble
  always_comb begin
    exm_d = mem_stall_c ? exm_q :
            md_done ? {1'b1, pc4, md_result, ID_EX_B, md_dest_q, ID_EX_op, 1'b0} :
            (ID_EX_valid && ok && !md) ? {1'b1, target, res, ID_EX_B, dst, ID_EX_op, tkn} : '0;
  end
  always_ff @(posedge clock) begin
    exm_q <= reset ? '0 : exm_d;
    md_dest_q <= md_dest_d;
  end
  assign {EX_MEM_valid, EX_MEM_targetPC, EX_MEM_result, EX_MEM_B, EX_MEM_dest, EX_MEM_op, EX_MEM_taken} = exm_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage
module tb_execute_stage;
  logic clock, reset, ID_EX_valid, mem_stall_c;
  logic [5:0] ID_EX_op, ID_EX_funct, EX_MEM_op;
  logic [4:0] ID_EX_shamt, ID_EX_dest, EX_MEM_dest;
  logic [31:0] ID_EX_A, ID_EX_B, ID_EX_PC, EX_MEM_targetPC, EX_MEM_result, EX_MEM_B;
  logic [15:0] ID_EX_imm;
  logic EX_MEM_taken, EX_MEM_valid, ex_stall_c;
  int checks = 0;
  int errors = 0;
  int n;
  execute_stage dut (
    .clock(clock), .reset(reset), .ID_EX_valid(ID_EX_valid), .ID_EX_op(ID_EX_op),
    .ID_EX_funct(ID_EX_funct), .ID_EX_shamt(ID_EX_shamt), .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B),
    .ID_EX_imm(ID_EX_imm), .ID_EX_dest(ID_EX_dest), .ID_EX_PC(ID_EX_PC), .mem_stall_c(mem_stall_c),
    .EX_MEM_targetPC(EX_MEM_targetPC), .EX_MEM_result(EX_MEM_result), .EX_MEM_B(EX_MEM_B),
    .EX_MEM_dest(EX_MEM_dest), .EX_MEM_op(EX_MEM_op), .EX_MEM_taken(EX_MEM_taken),
    .EX_MEM_valid(EX_MEM_valid), .ex_stall_c(ex_stall_c)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [5:0] op, input logic [5:0] funct, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input logic [4:0] dest);
    ID_EX_valid = 1;
    ID_EX_op = op;
    ID_EX_funct = funct;
    ID_EX_A = a;
    ID_EX_B = b;
    ID_EX_imm = imm;
    ID_EX_dest = dest;
  endtask
  task automatic md_wait(output int cnt);
    cnt = 0;
    while (ex_stall_c && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask
  task automatic run_md(input string tag, input logic [5:0] funct, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int c;
    issue(6'h00, funct, a, b, 16'h0, 5'd5);
    #1;
    md_wait(c);
    chk({tag, "_stall_cycles"}, c, 33);
    chk({tag, "_bubble_valid"}, EX_MEM_valid, 0);
    chk({tag, "_bubble_result"}, EX_MEM_result, 0);
    tick();
    chk({tag, "_result"}, EX_MEM_result, exp);
    chk({tag, "_dest"}, EX_MEM_dest, 5);
    chk({tag, "_valid"}, EX_MEM_valid, 1);
    ID_EX_valid = 0;
  endtask
  initial begin
    reset = 1;
    mem_stall_c = 0;
    ID_EX_shamt = 0;
    ID_EX_PC = 32'h100;
    issue(6'h00, 6'h21, 32'd9, 32'd9, 16'h0, 5'd1);
    tick();
    tick();
    chk("rst_valid", EX_MEM_valid, 0);
    chk("rst_result", EX_MEM_result, 0);
    chk("rst_target", EX_MEM_targetPC, 0);
    chk("rst_dest", EX_MEM_dest, 0);
    reset = 0;
    issue(6'h00, 6'h21, 32'd5, 32'd7, 16'h0, 5'd3);
    #1;
    chk("addu_stall", ex_stall_c, 0);
    tick();
    chk("addu_result", EX_MEM_result, 12);
    chk("addu_dest", EX_MEM_dest, 3);
    chk("addu_valid", EX_MEM_valid, 1);
    chk("addu_target", EX_MEM_targetPC, 32'h104);
    issue(6'h00, 6'h23, 32'd0, 32'd1, 16'h0, 5'd4);
    tick();
    chk("subu_result", EX_MEM_result, 32'hFFFF_FFFF);
    issue(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd4);
    tick();
    chk("slt_result", EX_MEM_result, 1);
    issue(6'h00, 6'h00, 32'd0, 32'd1, 16'h0, 5'd4);
    ID_EX_shamt = 4;
    tick();
    chk("sll_result", EX_MEM_result, 16);
    issue(6'h00, 6'h02, 32'd0, 32'h8000_0000, 16'h0, 5'd4);
    tick();
    chk("srl_result", EX_MEM_result, 32'h0800_0000);
    issue(6'h09, 6'h3F, 32'd10, 32'd0, 16'hFFFF, 5'd6);
    tick();
    chk("addiu_result", EX_MEM_result, 9);
    issue(6'h0D, 6'h3F, 32'h0F00_0000, 32'd0, 16'h8000, 5'd6);
    tick();
    chk("ori_result", EX_MEM_result, 32'h0F00_8000);
    issue(6'h0F, 6'h3F, 32'd0, 32'd0, 16'h1234, 5'd6);
    tick();
    chk("lui_result", EX_MEM_result, 32'h1234_0000);
    issue(6'h23, 6'h3F, 32'h100, 32'd0, 16'hFFFC, 5'd8);
    tick();
    chk("lw_addr", EX_MEM_result, 32'hFC);
    chk("lw_dest", EX_MEM_dest, 8);
    issue(6'h2B, 6'h3F, 32'h200, 32'hCAFE, 16'h0008, 5'd8);
    tick();
    chk("sw_addr", EX_MEM_result, 32'h208);
    chk("sw_data", EX_MEM_B, 32'hCAFE);
    chk("sw_dest", EX_MEM_dest, 0);
    issue(6'h00, 6'h3F, 32'd1, 32'd1, 16'h0, 5'd3);
    tick();
    chk("bad_funct_valid", EX_MEM_valid, 0);
    chk("bad_funct_dest", EX_MEM_dest, 0);
    issue(6'h00, 6'h21, 32'd1, 32'd1, 16'h0, 5'd3);
    ID_EX_valid = 0;
    tick();
    chk("invalid_valid", EX_MEM_valid, 0);
    issue(6'h04, 6'h3F, 32'd9, 32'd9, 16'd3, 5'd3);
    tick();
    chk("beq_t_target", EX_MEM_targetPC, 32'h110);
    chk("beq_t_taken", EX_MEM_taken, 1);
    chk("beq_t_dest", EX_MEM_dest, 0);
    issue(6'h04, 6'h3F, 32'd9, 32'd8, 16'd3, 5'd3);
    tick();
    chk("beq_nt_target", EX_MEM_targetPC, 32'h104);
    chk("beq_nt_taken", EX_MEM_taken, 0);
    issue(6'h05, 6'h3F, 32'd9, 32'd8, 16'hFFFF, 5'd3);
    tick();
    chk("bne_t_target", EX_MEM_targetPC, 32'h100);
    chk("bne_t_taken", EX_MEM_taken, 1);
    run_md("mult", 6'h18, 32'h0001_0003, 32'h0000_0010, 32'h0010_0030);
    run_md("divu", 6'h1B, 32'd100, 32'd7, 32'd14);
    run_md("divu0", 6'h1B, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue(6'h00, 6'h21, 32'd1, 32'd2, 16'h0, 5'd9);
    mem_stall_c = 1;
    #1;
    chk("mstall_ex_stall", ex_stall_c, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mstall_hold_result", EX_MEM_result, 32'hFFFF_FFFF);
      chk("mstall_hold_dest", EX_MEM_dest, 5);
    end
    mem_stall_c = 0;
    tick();
    chk("mstall_release_result", EX_MEM_result, 3);
    chk("mstall_release_dest", EX_MEM_dest, 9);
    issue(6'h00, 6'h18, 32'd3, 32'd4, 16'h0, 5'd7);
    #1;
    md_wait(n);
    chk("done_hold_cycles", n, 33);
    mem_stall_c = 1;
    #1;
    chk("done_hold_stall", ex_stall_c, 1);
    tick();
    tick();
    chk("done_hold_valid", EX_MEM_valid, 0);
    chk("done_hold_result", EX_MEM_result, 0);
    mem_stall_c = 0;
    #1;
    chk("done_release_stall", ex_stall_c, 0);
    tick();
    chk("done_commit_result", EX_MEM_result, 12);
    chk("done_commit_dest", EX_MEM_dest, 7);
    chk("done_commit_valid", EX_MEM_valid, 1);
    issue(6'h00, 6'h18, 32'd2, 32'd2, 16'h0, 5'd7);
    for (int i = 0; i < 5; i++) tick();
    chk("busy_stall", ex_stall_c, 1);
    reset = 1;
    ID_EX_valid = 0;
    tick();
    chk("busy_rst_valid", EX_MEM_valid, 0);
    chk("busy_rst_result", EX_MEM_result, 0);
    chk("busy_rst_target", EX_MEM_targetPC, 0);
    chk("busy_rst_stall", ex_stall_c, 0);
    reset = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("post_rst_valid", EX_MEM_valid, 0);
    end
    chk("post_rst_stall", ex_stall_c, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
